// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one memory request in
// flight and buffers returned words in an in-order prefetch queue.
module fetch_prefetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  STEP   = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0]  PC_RST = PC_W'(RESET_PC);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic               outstanding_q, outstanding_d;
    logic               discard_q, discard_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [INSTR_W-1:0] data_d [DEPTH];
    logic [PC_W-1:0]    pc_q [DEPTH];
    logic [PC_W-1:0]    pc_d [DEPTH];

    logic resp;
    logic push;
    logic pop;

    assign imem_addr = fetch_pc_q;
    assign instr     = data_q[rd_ptr_q];
    assign instr_pc  = pc_q[rd_ptr_q];

    // Handshakes; a pop never frees a slot for a request in the same cycle
    always_comb begin
        resp        = imem_rvalid && outstanding_q;
        push        = resp && !discard_q && !redir_valid;
        instr_valid = (count_q != '0) && !redir_valid;
        pop         = instr_valid && instr_ready;
        imem_req    = rst && !redir_valid
                   && (!outstanding_q || imem_rvalid)
                   && ((count_q + CNT_W'(push)) < FULL);
    end

    // Next state: redirect flushes the queue and retargets the PC
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        data_d        = data_q;
        pc_d          = pc_q;
        if (redir_valid) begin
            fetch_pc_d = redir_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (outstanding_q) begin
                // a response arriving now is simply dropped,
                // otherwise the pending one is marked stale
                outstanding_d = !imem_rvalid;
                discard_d     = !imem_rvalid;
            end
        end else begin
            if (resp) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (push) begin
                data_d[wr_ptr_q] = imem_rdata;
                pc_d[wr_ptr_q]   = req_pc_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (imem_req) begin
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + STEP;
                outstanding_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= PC_RST;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    localparam logic [7:0] RST_PC = 8'h00;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [7:0]  redir_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .PC_W(8), .INSTR_W(32), .DEPTH(DEPTH),
        .PC_STEP(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    typedef struct { logic [7:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [7:0] pc; bit stale; } fl_t;
    typedef struct {
        logic rdy; logic rd; logic [7:0] rpc;
        logic req; logic [7:0] addr; logic v; logic [7:0] ipc;
    } vec_t;

    ent_t       mq[$];
    fl_t        inflight[$];
    logic [7:0] m_pc;

    int         errors;
    int         checks;
    int         cyc;
    bit         mem_busy;
    logic [7:0] mem_addr;
    int         mem_due;
    int         lat_lo;
    int         lat_hi;

    logic        obs_req;
    logic [7:0]  obs_addr;
    logic        obs_valid;
    logic        obs_hs;
    logic [7:0]  obs_pc;
    logic [31:0] obs_instr;

    vec_t tbl[11];

    function automatic logic [31:0] word(input logic [7:0] a);
        return {8'hA0, ~a, 8'h5C, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        inflight.delete();
        m_pc     = RST_PC;
        mem_busy = 1'b0;
        cyc      = 0;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        redir_valid = 1'b0;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, compare with the model, advance everything
    task automatic step(input logic rdy, input logic rd,
                        input logic [7:0] rpc);
        bit   outst;
        bit   push;
        bit   mv;
        bit   mr;
        int   n;
        fl_t  f;
        ent_t e;
        instr_ready = rdy;
        redir_valid = rd;
        redir_pc    = rpc;
        if (mem_busy && mem_due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        n     = mq.size();
        outst = inflight.size() != 0;
        push  = 1'b0;
        if (outst && imem_rvalid && !rd) push = !inflight[0].stale;
        mv = (n != 0) && !rd;
        mr = !rd && (!outst || imem_rvalid)
             && ((n + (push ? 1 : 0)) < DEPTH);
        chk("imem_req", imem_req, mr);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, mv);
        if (mv) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].data);
        end
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_hs    = instr_valid && rdy;
        obs_pc    = instr_pc;
        obs_instr = instr;
        @(posedge clk);
        #1;
        if (imem_rvalid) mem_busy = 1'b0;
        if (obs_req) begin
            mem_busy = 1'b1;
            mem_addr = obs_addr;
            mem_due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        end
        if (rd) begin
            if (outst && imem_rvalid) f = inflight.pop_front();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mq.delete();
            m_pc = rpc;
        end else begin
            if (mv && rdy) e = mq.pop_front();
            if (outst && imem_rvalid) begin
                f = inflight.pop_front();
                if (!f.stale) mq.push_back('{f.pc, imem_rdata});
            end
            if (mr) begin
                inflight.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 8'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  nreq;
        int  nhs;
        int  seen08;
        bit  got;
        bit  found;
        logic rd;
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        instr_ready = 1'b0;
        lat_lo      = 1;
        lat_hi      = 1;
        mem_busy    = 1'b0;

        // reset values
        #2;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 8'h00);

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 1'b1, 8'h04};
        tbl[4]  = '{1'b1, 1'b1, 8'hF8, 1'b0, 8'h10, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hF8, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hF8};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'hFC};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 1'b1, 8'h04};

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // streaming, redirect with a same-cycle response, PC wrap
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            chk("tbl_req", obs_req, tbl[i].req);
            chk("tbl_addr", obs_addr, tbl[i].addr);
            chk("tbl_valid", obs_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk("tbl_pc", obs_pc, tbl[i].ipc);
                chk("tbl_instr", obs_instr, word(tbl[i].ipc));
            end
        end

        // backpressure: fill, stall, drain in order
        do_reset();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (obs_req) nreq++;
        end
        chk("bp_fill_reqs", nreq, 4);
        chk("bp_stalled_req", obs_req, 1'b0);
        chk("bp_head_valid", obs_valid, 1'b1);
        chk("bp_head_pc", obs_pc, 8'h00);
        nhs = 0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (obs_hs) begin
                chk("bp_drain_pc", obs_pc, 8'(nhs * 4));
                nhs++;
            end
            if (obs_req && !got) begin
                got = 1'b1;
                chk("bp_resume_addr", obs_addr, 8'h10);
            end
        end
        chk("bp_drain_count", nhs, 8);

        // latency 3, redirect while the 0x08 request is in flight
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        found  = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (obs_req && obs_addr == 8'h08) found = 1'b1;
        end
        chk("l3_req08_seen", found, 1'b1);
        step(1'b1, 1'b1, 8'h40);
        seen08 = 0;
        got    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (obs_valid && obs_pc == 8'h08) seen08++;
            if (obs_valid && !got) begin
                got = 1'b1;
                chk("l3_first_pc", obs_pc, 8'h40);
            end
        end
        chk("l3_no_stale", seen08, 0);
        chk("l3_got_valid", got, 1'b1);

        // redirect colliding with response and ready, two queued
        do_reset();
        lat_lo = 1;
        lat_hi = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h80);
        chk("r4_no_hs", obs_hs, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        chk("r4_valid_next", obs_valid, 1'b0);
        chk("r4_req_addr", obs_addr, 8'h80);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (obs_valid) begin
                got = 1'b1;
                chk("r4_first_pc", obs_pc, 8'h80);
            end
        end
        chk("r4_got_valid", got, 1'b1);

        // random traffic, latency 1..3
        do_reset();
        lat_lo = 1;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(99, 0) < 4);
            step($urandom_range(99, 0) < 70, rd, 8'($urandom));
        end

        // asynchronous reset with a request in flight
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        chk("mid_rst_valid", instr_valid, 1'b0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc", instr_pc, 8'h00);
        imem_rvalid = 1'b1;
        imem_rdata  = word(8'h10);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_valid", instr_valid, 1'b0);
        chk("mid_rst_hold_req", imem_req, 1'b0);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        rst = 1'b1;
        model_reset();
        lat_lo = 1;
        lat_hi = 1;
        step(1'b1, 1'b0, 8'h00);
        chk("restart_req", obs_req, 1'b1);
        chk("restart_addr", obs_addr, RST_PC);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (obs_valid) begin
                got = 1'b1;
                chk("restart_first_pc", obs_pc, RST_PC);
            end
        end
        chk("restart_got_valid", got, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch front end for the processor. It replaces the bare PC register and PC+4 adder with a fetch engine that owns the PC, issues requests to a variable-latency instruction memory, buffers returned words in an in-order prefetch queue, and hands instructions to decode through a valid/ready handshake. A redirect input (branch/jump) flushes the queue and discards any in-flight response.

## Interface
- `PC_W`, 8: width of PC and memory address.
- `INSTR_W`, 32: instruction width.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `PC_STEP`, 4: PC increment per sequential fetch.
- `RESET_PC`, 0: fetch address after reset.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: request valid; always accepted at the edge it is high.
- `imem_addr` out PC_W: request address; equals fetch PC.
- `imem_rvalid` in 1: response valid; responses return in order, latency ≥1 cycle.
- `imem_rdata` in INSTR_W: response word.
- `redir_valid` in 1: redirect strobe, one cycle.
- `redir_pc` in PC_W: new fetch address, used as-is (no alignment).
- `instr_valid` out 1: queue head valid.
- `instr` out INSTR_W: queue head instruction.
- `instr_pc` out PC_W: address the head was fetched from.
- `instr_ready` in 1: decode accepts head.

## Operation
- State: `fetch_pc`, queue (data + PC per entry, `count`, read/write pointers wrapping mod DEPTH), `outstanding` flag (max one request in flight), `req_pc` (address of in-flight request), `discard` flag.
- Issue: `imem_req` = rst high AND !redir_valid AND (!outstanding OR imem_rvalid) AND (count + push_this_cycle) < DEPTH. Pop in the same cycle is not credited. On issue: `req_pc`←fetch_pc, `fetch_pc`←fetch_pc+PC_STEP (mod 2^PC_W), `outstanding`←1.
- Response: imem_rvalid with `outstanding`=1 clears `outstanding` (unless a new request issues same cycle) and, if `discard`=0 and no redirect this cycle, pushes {req_pc, imem_rdata}. If `discard`=1 the word is dropped and `discard`←0. imem_rvalid with `outstanding`=0 is ignored.
- Pop: instr_valid AND instr_ready advances read pointer.
- `instr_valid` = (count≠0) AND !redir_valid. `instr`/`instr_pc` show head entry regardless of valid.
- Redirect (priority over push, pop, issue): `count`←0, pointers reset, `fetch_pc`←redir_pc, no request that cycle. If `outstanding`=1 and imem_rvalid=0, `discard`←1 (stale response dropped later); if imem_rvalid=1 that same cycle, the word is dropped and `outstanding`←0.
- Simultaneous push and pop: count unchanged. Queue never overflows by construction of the issue rule; no error output.

## Timing
- Reset (rst low, asynchronous): fetch_pc=RESET_PC, count=0, pointers 0, outstanding=0, discard=0, queue storage 0; outputs imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- First request in the first cycle with rst high. Request in cycle n, response in n+L, instr_valid in n+L+1.
- With L=1 and instr_ready=1: one request per cycle, one instruction per cycle steady state.
- Redirect in cycle r: new request to redir_pc in cycle r+1 (even if a stale response is pending, provided issue rule holds after it returns); first redirected instruction valid at r+1+L+1.
- `imem_req` and `instr_valid` are combinational from registered state plus imem_rvalid/redir_valid; no combinational path from instr_ready to imem_req.

## Test plan
- Reset release, L=1, ready=1, memory word = address: imem_addr 0x00,0x04,0x08,0x0C on consecutive cycles; instr_pc/instr 0x00,0x04,… with instr_valid continuous from cycle 3.
- Backpressure, DEPTH=4, ready=0: exactly 4 entries fill then imem_req stays 0; raise ready, words 0x00..0x0C drained in order, fetch resumes at 0x10 with no gaps or duplicates.
- L=3, redirect to 0x40 one cycle after request to 0x08: response for 0x08 discarded, next instr_pc=0x40, no instr_pc=0x08 ever valid.
- Redirect to 0x80 in same cycle as imem_rvalid and instr_ready with 2 queued: no pop handshake, instr_valid=0 next cycle, first valid instr_pc=0x80.
- PC wrap, PC_W=8, redirect to 0xF8: instr_pc sequence 0xF8,0xFC,0x00,0x04.
- rst asserted low mid-stream with outstanding request: all outputs reach reset values immediately; late imem_rvalid during reset ignored; after release fetch restarts at RESET_PC.
